// File: rtl/aes_pkg.sv
// Shared AES helpers for the sequential key schedule.
// Key-length codes, Nk/Nr/Nw lookups, GF(2^8) math, InvMixColumns column.
package aes_pkg;

  localparam logic [1:0] KL_128  = 2'd0;
  localparam logic [1:0] KL_192  = 2'd1;
  localparam logic [1:0] KL_256  = 2'd2;
  localparam logic [1:0] KL_RSVD = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GEN,
    S_DONE
  } ks_state_e;

  function automatic logic [3:0] nk_of(logic [1:0] kl);
    case (kl)
      KL_192:  return 4'd6;
      KL_256:  return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(logic [1:0] kl);
    case (kl)
      KL_192:  return 4'd12;
      KL_256:  return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [5:0] nw_of(logic [1:0] kl);
    case (kl)
      KL_192:  return 6'd52;
      KL_256:  return 6'd60;
      default: return 6'd44;
    endcase
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] inv_mix_col(logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {
      gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^
      gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
      gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^
      gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
      gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^
      gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
      gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^
      gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
    };
  endfunction

endpackage

// File: rtl/aes_key_schedule_seq_if.sv
// Key-load and round-key read bundle for aes_key_schedule_seq.
// AES_KSCHED_INV_EN adds rd_inv for equivalent-inverse-cipher keys.
interface aes_key_schedule_seq_if;
  logic [1:0]   key_len;
  logic [0:255] key_in;
  logic         start;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rd_round;
  logic [0:127] rd_key;
`ifdef AES_KSCHED_INV_EN
  logic         rd_inv;

  modport master (
    output key_len, key_in, start, rd_round, rd_inv,
    input  busy, done, keys_valid, rd_key
  );
  modport slave (
    input  key_len, key_in, start, rd_round, rd_inv,
    output busy, done, keys_valid, rd_key
  );
`else
  modport master (
    output key_len, key_in, start, rd_round,
    input  busy, done, keys_valid, rd_key
  );
  modport slave (
    input  key_len, key_in, start, rd_round,
    output busy, done, keys_valid, rd_key
  );
`endif
endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box: GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  logic [7:0] sq;
  logic [7:0] inv;

  // inv = a^(2+4+...+128) = a^254, which is 0 for a=0
  always_comb begin
    sq  = a;
    inv = 8'h01;
    for (int k = 0; k < 7; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    y = inv
      ^ {inv[6:0], inv[7]}
      ^ {inv[5:0], inv[7:6]}
      ^ {inv[4:0], inv[7:5]}
      ^ {inv[3:0], inv[7:4]}
      ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key expansion, one word per clock.
// Optional AES_KSCHED_INV_EN: InvMixColumns on middle round keys.
module aes_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int MAX_WORDS = 60
)(
  input  logic clk,
  input  logic rst,
  aes_key_schedule_seq_if.slave bus
);

  localparam int AW = $clog2(MAX_WORDS);

  ks_state_e      state_q, state_d;
  logic [1:0]     kl_q, kl_d;
  logic [AW-1:0]  i_q, i_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [7:0]     rcon_q, rcon_d;
  logic           keys_valid_q, keys_valid_d;
  logic [0:127]   rd_key_q, rd_key_d;
  logic [31:0]    store_q [MAX_WORDS];
  logic [31:0]    store_d [MAX_WORDS];

  logic [3:0]     nk;
  logic [3:0]     nk_in;
  logic [31:0]    prev_w, back_w;
  logic [31:0]    sub_in, sub_out;
  logic [31:0]    temp_w, new_w;

  assign nk = nk_of(kl_q);

  always_comb begin
    prev_w = store_q[i_q - AW'(1)];
    back_w = store_q[i_q - AW'(nk)];
    sub_in = (cnt_q == 4'd0) ? rot_word(prev_w) : prev_w;
  end

  // one shared SubWord for both the rcon step and the AES-256 mid step
  for (genvar b = 0; b < 4; b++) begin : g_sub
    aes_sbox u_sbox (
      .a (sub_in[8*b +: 8]),
      .y (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    temp_w = prev_w;
    if (cnt_q == 4'd0)
      temp_w = sub_out ^ {rcon_q, 24'h0};
    else if (nk == 4'd8 && cnt_q == 4'd4)
      temp_w = sub_out;
    new_w = back_w ^ temp_w;
  end

  always_comb begin
    state_d      = state_q;
    kl_d         = kl_q;
    i_d          = i_q;
    cnt_d        = cnt_q;
    rcon_d       = rcon_q;
    keys_valid_d = keys_valid_q;
    store_d      = store_q;
    nk_in        = nk_of(bus.key_len);
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && bus.key_len != KL_RSVD) begin
          kl_d = bus.key_len;
          for (int j = 0; j < 8; j++)
            if (j < int'(nk_in))
              store_d[j] = bus.key_in[32*j +: 32];
          i_d          = AW'(nk_in);
          cnt_d        = 4'd0;
          rcon_d       = 8'h01;
          keys_valid_d = 1'b0;
          state_d      = S_GEN;
        end
      end
      S_GEN: begin
        store_d[i_q] = new_w;
        i_d          = i_q + AW'(1);
        if (cnt_q == 4'd0) rcon_d = xtime(rcon_q);
        cnt_d = (cnt_q == nk - 4'd1) ? 4'd0 : cnt_q + 4'd1;
        if (i_q == AW'(nw_of(kl_q) - 6'd1)) begin
          state_d      = S_DONE;
          keys_valid_d = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic [AW-1:0] base;
  logic [31:0]   rd_w;

  always_comb begin
    rd_key_d = '0;
    base     = AW'({bus.rd_round, 2'b00});
    rd_w     = 32'h0;
    if (bus.rd_round <= nr_of(kl_q)) begin
      for (int w = 0; w < 4; w++) begin
        rd_w = store_q[base + AW'(w)];
`ifdef AES_KSCHED_INV_EN
        if (bus.rd_inv && bus.rd_round != 4'd0 &&
            bus.rd_round < nr_of(kl_q))
          rd_w = inv_mix_col(rd_w);
`endif
        rd_key_d[32*w +: 32] = rd_w;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      kl_q         <= KL_128;
      i_q          <= '0;
      cnt_q        <= 4'd0;
      rcon_q       <= 8'h01;
      keys_valid_q <= 1'b0;
      rd_key_q     <= '0;
    end else begin
      state_q      <= state_d;
      kl_q         <= kl_d;
      i_q          <= i_d;
      cnt_q        <= cnt_d;
      rcon_q       <= rcon_d;
      keys_valid_q <= keys_valid_d;
      rd_key_q     <= rd_key_d;
    end
  end

  // contents are qualified by keys_valid, so the store has no reset
  always_ff @(posedge clk) begin
    store_q <= store_d;
  end

  assign bus.busy       = (state_q == S_GEN);
  assign bus.done       = (state_q == S_DONE);
  assign bus.keys_valid = keys_valid_q;
  assign bus.rd_key     = rd_key_q;

endmodule
